gray_cnt_mon: RTL and testbench
===============================

// Module: gray_cnt_mon
// PURPOSE
//  Receive end of the gray-coded count bus. Samples a gray count (WIDTH bits, same clk
//  domain), decodes it to binary, checks each new value is a hold or a +1 step
//  (mod 2^WIDTH), and reports steps, wraps and errors. Sits downstream of the gray
//  counter as a checker/decoder. Provides a binary count plus a wrap tick.
// PARAMETERS
//  WIDTH      4  gray/binary count width (>=2)
//  ERR_CNT_W  8  width of saturating error counter (>=1)
//  ERR_LIMIT  3  consecutive errors that force loss of lock (>=1)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          reset: synchronous, active-high
//  gray_in    in   WIDTH      gray-coded count, sampled when valid_in=1
//  valid_in   in   1          sample qualifier
//  bin_out    out  WIDTH      decoded binary of last accepted sample
//  bin_valid  out  1          1-cycle pulse: bin_out updated
//  step       out  1          1-cycle pulse: new value == previous+1 mod 2^WIDTH
//  wrap       out  1          1-cycle pulse: step from 2^WIDTH-1 to 0 (step also 1)
//  err        out  1          1-cycle pulse: new value neither hold nor +1
//  err_cnt    out  ERR_CNT_W  total errors since reset, saturates at all-ones
//  locked     out  1          1 = reference value held, checking active
// BEHAVIOUR
//  - Reset (rst=1 at edge): all outputs 0, pipeline valid bits cleared, state UNLOCKED,
//    consecutive-error count 0. Samples in flight discarded.
//  - Pipeline: stage1 registers gray_in when valid_in; stage2 decodes/compares and
//    registers outputs. valid_in=1 in cycle k -> bin_valid/step/wrap/err in cycle k+2.
//    Full throughput: one sample per cycle; gaps in valid_in allowed, no outputs pulse.
//  - Decode: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i=WIDTH-2..0.
//  - Compare: prev = bin_out; +1 computed in WIDTH bits (natural wrap).
//  - FSM UNLOCKED: accepted sample -> bin_out=value, bin_valid=1, step/err=0,
//    go LOCKED (locked=1 same cycle as bin_valid).
//  - FSM LOCKED, accepted sample:
//    value==prev  : bin_valid=1, step=0, err=0, consec_err=0.
//    value==prev+1: bin_valid=1, step=1, wrap=(prev==all-ones), consec_err=0.
//    otherwise    : bin_valid=1, err=1, bin_out resyncs to value, err_cnt+1 (saturating),
//                   consec_err+1; if consec_err reaches ERR_LIMIT -> UNLOCKED,
//                   locked=0, consec_err=0.
//  - Next sample after loss of lock relocks as in UNLOCKED (no step, no err).
//  - step, wrap, err mutually exclusive except wrap implies step.
//  - bin_out/locked/err_cnt hold between samples.
//  - rst overrides any simultaneous valid_in.
// TESTING
//  1 rst, then 17 contiguous samples bin 0..15,0 (gray 0000..1000,0000) -> locked after
//    1st, 16 step pulses, 1 wrap (last), err=0, bin_out=0.
//  2 lock on gray 0110 (bin4), repeat 0110 twice -> bin_valid x3, step=0, err=0, bin_out=4.
//  3 gray 0111 (5), 0100 (7), 1100 (8) -> err on 7, err_cnt=1, bin_out=7, step on 8.
//  4 ERR_CNT_W=2: lock, then 5 non-consecutive errors (valid step between) -> err_cnt=3,
//    locked stays 1.
//  5 ERR_LIMIT=3: lock on 0, then bins 5,9,2 -> 3 err pulses, locked=0 after 3rd;
//    next sample bin 6 -> locked=1, no step, no err.
//  6 valid_in gaps + rst asserted 1 cycle after a valid sample -> no pulse from that
//    sample, all outputs 0, locked=0; next sample relocks.

Source files
------------

// File: rtl/gray_cnt_mon.sv
// gray_cnt_mon: receive-side checker/decoder for a gray-coded count bus.
// Stage 1 captures qualified gray samples. Stage 2 decodes them to binary and
// compares each value against the last accepted one. It reports holds, +1 steps,
// wraps and errors, and drops lock after ERR_LIMIT consecutive errors.
module gray_cnt_mon #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 valid_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step,
  output logic                 wrap,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 locked
);

  // The consecutive-error count never needs to hold more than ERR_LIMIT-1.
  localparam int CONSEC_W = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT);
  localparam logic [CONSEC_W-1:0]  CONSEC_LAST = CONSEC_W'(ERR_LIMIT - 1);
  localparam logic [CONSEC_W-1:0]  CONSEC_ONE  = CONSEC_W'(32'd1);
  localparam logic [CONSEC_W-1:0]  CONSEC_ZERO = CONSEC_W'(32'd0);
  localparam logic [WIDTH-1:0]     BIN_ONE     = WIDTH'(32'd1);
  localparam logic [WIDTH-1:0]     BIN_ONES    = {WIDTH{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE     = ERR_CNT_W'(32'd1);
  localparam logic [ERR_CNT_W-1:0] ERR_ONES    = {ERR_CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t                 state_r, state_nxt_s;
  logic                   s1_valid_r;
  logic [WIDTH-1:0]       s1_gray_r;
  logic [WIDTH-1:0]       s2_bin_s;
  logic [CONSEC_W-1:0]    consec_r, consec_nxt_s;
  logic [WIDTH-1:0]       bin_nxt_s;
  logic                   bin_valid_nxt_s, step_nxt_s, wrap_nxt_s, err_nxt_s, locked_nxt_s;
  logic [ERR_CNT_W-1:0]   err_cnt_nxt_s;

  assign s2_bin_s = gray2bin(s1_gray_r);

  // Stage 1: capture the gray sample and its qualifier.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_gray_r  <= {WIDTH{1'b0}};
    end else begin
      s1_valid_r <= valid_in;
      if (valid_in) begin
        s1_gray_r <= gray_in;
      end
    end
  end

  // Stage 2 decision: classify the decoded sample and compute the next state and outputs.
  always_comb begin
    state_nxt_s     = state_r;
    consec_nxt_s    = consec_r;
    bin_nxt_s       = bin_out;
    bin_valid_nxt_s = 1'b0;
    step_nxt_s      = 1'b0;
    wrap_nxt_s      = 1'b0;
    err_nxt_s       = 1'b0;
    err_cnt_nxt_s   = err_cnt;
    locked_nxt_s    = locked;
    if (s1_valid_r) begin
      bin_valid_nxt_s = 1'b1;
      case (state_r)
        ST_UNLOCKED: begin
          bin_nxt_s    = s2_bin_s;
          state_nxt_s  = ST_LOCKED;
          locked_nxt_s = 1'b1;
          consec_nxt_s = CONSEC_ZERO;
        end
        ST_LOCKED: begin
          if (s2_bin_s == bin_out) begin
            consec_nxt_s = CONSEC_ZERO;
          end else if (s2_bin_s == (bin_out + BIN_ONE)) begin
            bin_nxt_s    = s2_bin_s;
            step_nxt_s   = 1'b1;
            wrap_nxt_s   = (bin_out == BIN_ONES);
            consec_nxt_s = CONSEC_ZERO;
          end else begin
            bin_nxt_s = s2_bin_s;
            err_nxt_s = 1'b1;
            if (err_cnt != ERR_ONES) begin
              err_cnt_nxt_s = err_cnt + ERR_ONE;
            end else begin
              err_cnt_nxt_s = err_cnt;
            end
            if (consec_r >= CONSEC_LAST) begin
              state_nxt_s  = ST_UNLOCKED;
              locked_nxt_s = 1'b0;
              consec_nxt_s = CONSEC_ZERO;
            end else begin
              consec_nxt_s = consec_r + CONSEC_ONE;
            end
          end
        end
        default: begin
          state_nxt_s  = ST_UNLOCKED;
          locked_nxt_s = 1'b0;
          consec_nxt_s = CONSEC_ZERO;
        end
      endcase
    end else begin
      bin_valid_nxt_s = 1'b0;
    end
  end

  // Stage 2 registers: FSM state, error bookkeeping and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_UNLOCKED;
      consec_r  <= CONSEC_ZERO;
      bin_out   <= {WIDTH{1'b0}};
      bin_valid <= 1'b0;
      step      <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= {ERR_CNT_W{1'b0}};
      locked    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      consec_r  <= consec_nxt_s;
      bin_out   <= bin_nxt_s;
      bin_valid <= bin_valid_nxt_s;
      step      <= step_nxt_s;
      wrap      <= wrap_nxt_s;
      err       <= err_nxt_s;
      err_cnt   <= err_cnt_nxt_s;
      locked    <= locked_nxt_s;
    end
  end

endmodule

// File: tb/tb_gray_cnt_mon.sv
// tb_gray_cnt_mon: directed self-checking bench for gray_cnt_mon.
// u_dut uses default parameters; u_dut2 (ERR_CNT_W=2) shares the same stimulus
// for the saturating error counter scenario.
module tb_gray_cnt_mon;

  logic       clk;
  logic       rst;
  logic [3:0] gray_in;
  logic       valid_in;

  logic [3:0] bin_out;
  logic       bin_valid, step, wrap, err, locked;
  logic [7:0] err_cnt;

  logic [3:0] bin_out2;
  logic       bin_valid2, step2, wrap2, err2, locked2;
  logic [1:0] err_cnt2;

  int n_tests;
  int n_fail;

  gray_cnt_mon #(.WIDTH(4), .ERR_CNT_W(8), .ERR_LIMIT(3)) u_dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .valid_in(valid_in),
    .bin_out(bin_out), .bin_valid(bin_valid), .step(step), .wrap(wrap),
    .err(err), .err_cnt(err_cnt), .locked(locked)
  );

  gray_cnt_mon #(.WIDTH(4), .ERR_CNT_W(2), .ERR_LIMIT(3)) u_dut2 (
    .clk(clk), .rst(rst), .gray_in(gray_in), .valid_in(valid_in),
    .bin_out(bin_out2), .bin_valid(bin_valid2), .step(step2), .wrap(wrap2),
    .err(err2), .err_cnt(err_cnt2), .locked(locked2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample: outputs for it are visible after the second tick.
  task automatic send(input logic [3:0] g);
    gray_in  = g;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    gray_in  = 4'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    valid_in = 1'b1;
    gray_in  = 4'b0101;
    tick();
    tick();
    n_tests++;
    if ({bin_valid, step, wrap, err, locked} !== 5'b00000 || bin_out !== 4'd0 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: flags=%b bin_out=%0d err_cnt=%0d, expected all 0",
               {bin_valid, step, wrap, err, locked}, bin_out, err_cnt);
    end
    rst      = 1'b0;
    valid_in = 1'b0;
    tick();
    n_tests++;
    if ({bin_valid, locked} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_valid_override: bin_valid,locked=%b expected 00", {bin_valid, locked});
    end
  endtask

  task automatic test_count();
    int         steps;
    int         wraps;
    int         errs;
    logic [3:0] exp_bin;
    logic [4:0] exp_flags;
    steps = 0;
    wraps = 0;
    errs  = 0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (i < 17) begin
        gray_in  = b2g(4'(i));
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      tick();
      if (i >= 1) begin
        exp_bin   = 4'(i - 1);
        exp_flags = (i == 1) ? 5'b10001 : ((i == 17) ? 5'b11101 : 5'b11001);
        if (step) steps++;
        if (wrap) wraps++;
        if (err)  errs++;
        n_tests++;
        if ({bin_valid, step, wrap, err, locked} !== exp_flags || bin_out !== exp_bin) begin
          n_fail++;
          $display("FAIL count_sample%0d: flags=%b bin_out=%0d expected flags=%b bin_out=%0d",
                   i - 1, {bin_valid, step, wrap, err, locked}, bin_out, exp_flags, exp_bin);
        end
      end
    end
    n_tests++;
    if (steps != 16 || wraps != 1 || errs != 0) begin
      n_fail++;
      $display("FAIL count_totals: steps=%0d wraps=%0d errs=%0d expected 16 1 0", steps, wraps, errs);
    end
    tick();
    n_tests++;
    if ({bin_valid, step, wrap, err, locked} !== 5'b00001 || bin_out !== 4'd0) begin
      n_fail++;
      $display("FAIL count_idle: flags=%b bin_out=%0d expected 00001 0",
               {bin_valid, step, wrap, err, locked}, bin_out);
    end
  endtask

  task automatic test_hold();
    int nvalid;
    nvalid = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(4'b0110);
      if (bin_valid) nvalid++;
      n_tests++;
      if ({step, wrap, err, locked} !== 4'b0001 || bin_out !== 4'd4) begin
        n_fail++;
        $display("FAIL hold_%0d: step,wrap,err,locked=%b bin_out=%0d expected 0001 4",
                 i, {step, wrap, err, locked}, bin_out);
      end
    end
    n_tests++;
    if (nvalid != 3) begin
      n_fail++;
      $display("FAIL hold_bin_valid: count=%0d expected 3", nvalid);
    end
  endtask

  task automatic test_err_step();
    send(4'b0111);
    n_tests++;
    if ({bin_valid, step, err} !== 3'b110 || bin_out !== 4'd5) begin
      n_fail++;
      $display("FAIL errstep_5: bv,step,err=%b bin_out=%0d expected 110 5", {bin_valid, step, err}, bin_out);
    end
    send(4'b0100);
    n_tests++;
    if ({bin_valid, step, wrap, err, locked} !== 5'b10011 || bin_out !== 4'd7 || err_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL errstep_7: flags=%b bin_out=%0d err_cnt=%0d expected 10011 7 1",
               {bin_valid, step, wrap, err, locked}, bin_out, err_cnt);
    end
    send(4'b1100);
    n_tests++;
    if ({bin_valid, step, wrap, err, locked} !== 5'b11001 || bin_out !== 4'd8 || err_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL errstep_8: flags=%b bin_out=%0d err_cnt=%0d expected 11001 8 1",
               {bin_valid, step, wrap, err, locked}, bin_out, err_cnt);
    end
  endtask

  task automatic test_err_sat();
    logic [3:0] seq [10];
    seq = '{4'd0, 4'd5, 4'd6, 4'd10, 4'd11, 4'd2, 4'd3, 4'd8, 4'd9, 4'd14};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(b2g(seq[i]));
    end
    n_tests++;
    if (err_cnt2 !== 2'd3 || locked2 !== 1'b1 || err2 !== 1'b1 || bin_out2 !== 4'd14) begin
      n_fail++;
      $display("FAIL errsat_w2: err_cnt=%0d locked=%b err=%b bin_out=%0d expected 3 1 1 14",
               err_cnt2, locked2, err2, bin_out2);
    end
    n_tests++;
    if (err_cnt !== 8'd5 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL errsat_w8: err_cnt=%0d locked=%b expected 5 1", err_cnt, locked);
    end
    n_tests++;
    if ({bin_valid2, step2, wrap2} !== 3'b100) begin
      n_fail++;
      $display("FAIL errsat_flags: bv,step,wrap=%b expected 100", {bin_valid2, step2, wrap2});
    end
  endtask

  task automatic test_lock_loss();
    logic [3:0] seq [3];
    logic [2:0] exp_lock;
    seq      = '{4'd5, 4'd9, 4'd2};
    exp_lock = 3'b011;
    do_reset();
    send(b2g(4'd0));
    for (int i = 0; i < 3; i++) begin
      send(b2g(seq[i]));
      n_tests++;
      if ({bin_valid, step, err} !== 3'b101 || locked !== exp_lock[i] || bin_out !== seq[i]) begin
        n_fail++;
        $display("FAIL lockloss_err%0d: bv,step,err=%b locked=%b bin_out=%0d expected 101 %b %0d",
                 i, {bin_valid, step, err}, locked, bin_out, exp_lock[i], seq[i]);
      end
    end
    send(b2g(4'd6));
    n_tests++;
    if ({bin_valid, step, wrap, err, locked} !== 5'b10001 || bin_out !== 4'd6 || err_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL lockloss_relock: flags=%b bin_out=%0d err_cnt=%0d expected 10001 6 3",
               {bin_valid, step, wrap, err, locked}, bin_out, err_cnt);
    end
  endtask

  task automatic test_gap_rst();
    int pulses;
    pulses = 0;
    do_reset();
    send(b2g(4'd3));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bin_valid || step || err) pulses++;
    end
    n_tests++;
    if (pulses != 0 || locked !== 1'b1 || bin_out !== 4'd3) begin
      n_fail++;
      $display("FAIL gap_idle: pulses=%0d locked=%b bin_out=%0d expected 0 1 3", pulses, locked, bin_out);
    end
    gray_in  = b2g(4'd4);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({bin_valid, step, wrap, err, locked} !== 5'b00000 || bin_out !== 4'd0 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL gap_flush: flags=%b bin_out=%0d err_cnt=%0d expected 00000 0 0",
               {bin_valid, step, wrap, err, locked}, bin_out, err_cnt);
    end
    send(b2g(4'd9));
    n_tests++;
    if ({bin_valid, step, wrap, err, locked} !== 5'b10001 || bin_out !== 4'd9) begin
      n_fail++;
      $display("FAIL gap_relock: flags=%b bin_out=%0d expected 10001 9",
               {bin_valid, step, wrap, err, locked}, bin_out);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    gray_in  = 4'd0;
    test_reset();
    test_count();
    test_hold();
    test_err_step();
    test_err_sat();
    test_lock_loss();
    test_gap_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
